// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/memory-stage bus arbiter.
package mem_arb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int MASK_W     = DATA_W_DEF / 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_I  = 3'd1,
        WAIT_I = 3'd2,
        REQ_D  = 3'd3,
        WAIT_D = 3'd4
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction fetch and load/store, one transaction
// outstanding, data port has priority; stale fetches after a branch are dropped.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                flush_f,
    output logic                if_valid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_mask,
    output logic                d_valid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_mask,
    input  logic                bus_gnt,
    input  logic                bus_rvalid,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                stall_f,
    output logic                stall_m,
    output arb_state_e          dbg_state
);

    // Handshake: bus_req stays high with a stable payload until bus_gnt is seen;
    // x_req is held by the requester until its one-cycle x_valid pulse.

    arb_state_e          state_q,     state_d;
    logic                drop_q,      drop_d;
    logic                bus_req_q,   bus_req_d;
    logic                bus_we_q,    bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q,  bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [DATA_W/8-1:0] bus_mask_q,  bus_mask_d;
    logic                if_valid_q,  if_valid_d;
    logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
    logic                d_valid_q,   d_valid_d;
    logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;

    logic d_elig;
    logic if_elig;

    // A port whose completion pulse is high this cycle is not reissued.
    assign d_elig  = d_req & ~d_valid_q;
    assign if_elig = if_req & ~if_valid_q;

    always_comb begin
        state_d     = state_q;
        drop_d      = drop_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_mask_d  = bus_mask_q;
        if_valid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_valid_d   = 1'b0;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (d_elig) begin
                    state_d     = REQ_D;
                    bus_req_d   = 1'b1;
                    bus_we_d    = d_we;
                    bus_addr_d  = d_addr;
                    bus_wdata_d = d_wdata;
                    bus_mask_d  = d_mask;
                end else if (if_elig) begin
                    state_d     = REQ_I;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = '0;
                    bus_mask_d  = '1;
                    drop_d      = flush_f;
                end
            end
            REQ_I: begin
                if (flush_f) drop_d = 1'b1;
                if (bus_gnt) begin
                    state_d   = WAIT_I;
                    bus_req_d = 1'b0;
                end
            end
            WAIT_I: begin
                if (flush_f) drop_d = 1'b1;
                if (bus_rvalid) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                    // A flush arriving with the response still makes it stale.
                    if (!(drop_q | flush_f)) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = bus_rdata;
                    end
                end
            end
            REQ_D: begin
                if (bus_gnt) begin
                    state_d   = WAIT_D;
                    bus_req_d = 1'b0;
                end
            end
            WAIT_D: begin
                if (bus_rvalid) begin
                    state_d   = IDLE;
                    d_valid_d = 1'b1;
                    if (!bus_we_q) d_rdata_d = bus_rdata;
                end
            end
            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
                drop_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            drop_q      <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_mask_q  <= '0;
            if_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_valid_q   <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            drop_q      <= drop_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_mask_q  <= bus_mask_d;
            if_valid_q  <= if_valid_d;
            if_rdata_q  <= if_rdata_d;
            d_valid_q   <= d_valid_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_valid  = if_valid_q;
    assign if_rdata  = if_rdata_q;
    assign d_valid   = d_valid_q;
    assign d_rdata   = d_rdata_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_mask  = bus_mask_q;
    assign stall_f   = if_elig;
    assign stall_m   = d_elig;
    assign dbg_state = state_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares one unified memory bus between the fetch stage (instruction reads) and the memory stage (loads/stores) of the RV32I 5-stage pipeline. It serialises requests, holds one transaction outstanding at a time, and returns read data and completion pulses to each requester. It drives `stall_f`/`stall_m` into the pipeline stall/flush logic so stages freeze while their access is pending. It also discards fetch responses made stale by a taken branch.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; mask width is `DATA_W/8`

Ports:
- `clk` in 1: single clock
- `rst_n` in 1: reset, asynchronous, active-low
- `if_req` in 1: fetch request, held until `if_valid`
- `if_addr` in ADDR_W: fetch address
- `flush_f` in 1: branch taken; the in-flight fetch is stale
- `if_valid` out 1: one-cycle fetch completion pulse
- `if_rdata` out DATA_W: instruction word, valid while `if_valid`=1
- `d_req` in 1: data request, held until `d_valid`
- `d_we` in 1: 1 = store
- `d_addr` in ADDR_W: data address
- `d_wdata` in DATA_W: store data
- `d_mask` in DATA_W/8: byte enables
- `d_valid` out 1: one-cycle data completion pulse
- `d_rdata` out DATA_W: load data
- `bus_req` out 1: bus request
- `bus_we` out 1: bus write enable
- `bus_addr` out ADDR_W: bus address
- `bus_wdata` out DATA_W: bus write data
- `bus_mask` out DATA_W/8: bus byte enables
- `bus_gnt` in 1: request accepted
- `bus_rvalid` in 1: response; read data valid, or write ack
- `bus_rdata` in DATA_W: bus read data
- `stall_f` out 1: fetch stage must hold
- `stall_m` out 1: memory stage must hold

## Operation
- FSM states: `IDLE`, `REQ_I`, `WAIT_I`, `REQ_D`, `WAIT_D`.
- `IDLE`:
  - eligible data request = `d_req & ~d_valid`; eligible fetch request = `if_req & ~if_valid`.
  - Data has strict priority (older instruction).
  - Winner's payload is latched into the bus registers; go to `REQ_D` or `REQ_I`.
  - Fetch payload: `bus_we`=0, `bus_mask`=all ones.
- `REQ_x`: `bus_req`=1, payload stable. On `bus_gnt` go to `WAIT_x`. `bus_req` is never withdrawn before grant.
- `WAIT_x`: `bus_req`=0. On `bus_rvalid`:
  - register `bus_rdata` into `x_rdata` (loads/fetches only; `d_rdata` unchanged on stores);
  - pulse `x_valid` next cycle;
  - go to `IDLE`.
- Drop flag:
  - Set by `flush_f` while in `REQ_I` or `WAIT_I`, or in the `IDLE` cycle that launches a fetch.
  - When set, the fetch still completes on the bus, but `if_valid` is suppressed and `if_rdata` is not updated.
  - Cleared on entry to `IDLE`.
- `flush_f` in the cycle `if_valid`=1 has no effect; the pipeline discards that word itself.
- `stall_f = if_req & ~if_valid`; `stall_m = d_req & ~d_valid`. Both are combinational from registered state.
- Requesters may change address/req the cycle after `x_valid`. A port whose `x_valid` is high is ignored by `IDLE` that cycle, so no duplicate reissue occurs.

## Timing
- Reset values: state `IDLE`; `bus_req`, `if_valid`, `d_valid`, drop flag = 0; `bus_*` payload, `if_rdata`, `d_rdata` = 0. `stall_*` follow their inputs.
- Minimum latency, with `bus_gnt` in the first `REQ` cycle and `bus_rvalid` one cycle later:
  - req seen cycle 0;
  - `bus_req` cycle 1;
  - `bus_rvalid` cycle 2;
  - `x_valid` cycle 3.
- Back-to-back: the next transaction's `bus_req` is asserted at the earliest in the cycle after `x_valid`.
- Simultaneous `if_req`/`d_req` in `IDLE`: data served first; fetch launches in the `IDLE` cycle after `d_valid`.
- Reset mid-transaction: immediate return to `IDLE`, outputs at reset values. The bus slave is reset by the same `rst_n`.
- `bus_rvalid` outside `WAIT_x` is ignored.

## Structure
- Shared package `mem_arb_pkg`: state enum `arb_state_e` and the mask-width constant.
- Single module. Payload mux/registers and FSM are small enough that no sub-module is warranted.

## Test plan
- Single fetch `if_addr`=0x0000_0010, slave gnt immediate, rdata 0x0000_0013 one cycle later → `if_valid` cycle 3, `if_rdata`=0x0000_0013, `stall_f` high cycles 0-2.
- Simultaneous `d_req` load 0x100 and `if_req` 0x20 → data bus transaction first, `d_valid` before any fetch `bus_req`. Fetch then issued with `bus_addr`=0x20.
- Store `d_addr`=0x200, `d_wdata`=0xDEADBEEF, `d_mask`=4'b0011 → bus payload matches exactly, `d_valid` after write ack, `d_rdata` unchanged.
- `bus_gnt` delayed 4 cycles → `bus_req` and payload stable all 4 cycles. Completion arrives 4 cycles later than the immediate-grant case.
- `flush_f` during `WAIT_I` → no `if_valid`, `if_rdata` unchanged. Next fetch to new address completes normally.
- `rst_n` low during `WAIT_D` → all outputs at reset values immediately. After release, a fresh load completes normally.
